branch_predict_ctrl: RTL and testbench

- Fetch-side branch predictor and redirect controller that sits beside the EX-stage branch decision unit.
- Holds a direct-mapped BTB with 2-bit saturating counters. The IF stage reads it for a prediction; the EX stage trains it with the resolved branch outcome.
- On a misprediction it issues a redirect PC and flushes the younger pipeline stages.
- Keeps 32-bit branch and mispredict performance counters.

---
 rtl/branch_predict_ctrl_pkg.sv | 35 +++
 rtl/branch_predict_ctrl_btb_table.sv | 65 ++++++
 rtl/branch_predict_ctrl.sv | 139 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the fetch-side branch predictor: branch-type codes,
// BTB geometry/field widths, controller states and the 2-bit counter update.
package branch_predict_ctrl_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  localparam int BTB_IDX_W = 6;
  localparam int BTB_TGT_W = 32;
  localparam int BTB_CNT_W = 2;
  localparam logic [BTB_CNT_W-1:0] BTB_CNT_ALLOC = 2'd2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  function automatic int btb_tag_w(input int idx_w);
    return 30 - idx_w;
  endfunction

  function automatic logic [BTB_CNT_W-1:0] cnt_update(input logic [BTB_CNT_W-1:0] cnt,
                                                      input logic taken);
    if (taken) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (IF lookup, EX training
// lookup), one synchronous entry write port and a valid-clear port for table init.
module btb_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W,
  parameter int TAG_W = btb_tag_w(BTB_IDX_W)
) (
  input  logic                 clk,
  input  logic [IDX_W-1:0]     ra_idx_i,
  output logic                 ra_valid_o,
  output logic [TAG_W-1:0]     ra_tag_o,
  output logic [BTB_TGT_W-1:0] ra_target_o,
  output logic [BTB_CNT_W-1:0] ra_cnt_o,
  input  logic [IDX_W-1:0]     rb_idx_i,
  output logic                 rb_valid_o,
  output logic [TAG_W-1:0]     rb_tag_o,
  output logic [BTB_TGT_W-1:0] rb_target_o,
  output logic [BTB_CNT_W-1:0] rb_cnt_o,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [BTB_TGT_W-1:0] wr_target_i,
  input  logic [BTB_CNT_W-1:0] wr_cnt_i,
  input  logic                 clr_i,
  input  logic [IDX_W-1:0]     clr_idx_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q    [DEPTH];
  logic [BTB_TGT_W-1:0] target_q [DEPTH];
  logic [BTB_CNT_W-1:0] cnt_q    [DEPTH];

  // Clear has priority; the controller never trains while init is running.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (clr_i && clr_idx_i == IDX_W'(gi)) begin
        valid_q[gi] <= 1'b0;
      end else if (we_i && wr_idx_i == IDX_W'(gi)) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
      cnt_q[wr_idx_i]    <= wr_cnt_i;
    end
  end

  assign ra_valid_o  = valid_q[ra_idx_i];
  assign ra_tag_o    = tag_q[ra_idx_i];
  assign ra_target_o = target_q[ra_idx_i];
  assign ra_cnt_o    = cnt_q[ra_idx_i];

  assign rb_valid_o  = valid_q[rb_idx_i];
  assign rb_tag_o    = tag_q[rb_idx_i];
  assign rb_target_o = target_q[rb_idx_i];
  assign rb_cnt_o    = cnt_q[rb_idx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor / redirect controller: BTB lookup for IF, training and
// mispredict redirect from EX, table-init FSM and performance counters.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  ex_br_type,
  input  logic        ex_br,
  input  logic [31:0] ex_br_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        ready,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int TAG_W = btb_tag_w(IDX_W);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      mispred_count_q, mispred_count_d;
  logic             clr;

  logic [IDX_W-1:0]     if_idx, ex_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;
  logic                 if_rd_valid, ex_rd_valid;
  logic [TAG_W-1:0]     if_rd_tag, ex_rd_tag;
  logic [BTB_TGT_W-1:0] if_rd_target, ex_rd_target;
  logic [BTB_CNT_W-1:0] if_rd_cnt, ex_rd_cnt;

  logic                 if_hit, ex_hit, ex_act, mispredict;
  logic                 train_we;
  logic [BTB_TGT_W-1:0] wr_target;
  logic [BTB_CNT_W-1:0] wr_cnt;
  logic                 unused_pc_lsbs;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  btb_table #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk         (clk),
    .ra_idx_i    (if_idx),
    .ra_valid_o  (if_rd_valid),
    .ra_tag_o    (if_rd_tag),
    .ra_target_o (if_rd_target),
    .ra_cnt_o    (if_rd_cnt),
    .rb_idx_i    (ex_idx),
    .rb_valid_o  (ex_rd_valid),
    .rb_tag_o    (ex_rd_tag),
    .rb_target_o (ex_rd_target),
    .rb_cnt_o    (ex_rd_cnt),
    .we_i        (train_we),
    .wr_idx_i    (ex_idx),
    .wr_tag_i    (ex_tag),
    .wr_target_i (wr_target),
    .wr_cnt_i    (wr_cnt),
    .clr_i       (clr),
    .clr_idx_i   (init_idx_q)
  );

  assign ready = (state_q == ST_RUN);

  // Valid bits are stale until init finishes, so ready gates every hit.
  assign if_hit      = ready & if_rd_valid & (if_rd_tag == if_tag);
  assign pred_taken  = if_hit & if_rd_cnt[1];
  assign pred_target = pred_taken ? if_rd_target : if_pc + 32'd4;

  assign ex_act     = ex_valid & ~ex_stall & (br_type_e'(ex_br_type) != NOBRANCH);
  assign mispredict = ex_act & ((ex_br != ex_pred_taken) |
                                (ex_br & ex_pred_taken & (ex_br_target != ex_pred_target)));

  assign redirect    = mispredict;
  assign flush_ifid  = mispredict;
  assign flush_idex  = mispredict;
  assign redirect_pc = ex_br ? ex_br_target : ex_pc + 32'd4;

  // A miss that resolves not-taken leaves the table untouched.
  assign ex_hit    = ex_rd_valid & (ex_rd_tag == ex_tag);
  assign train_we  = ex_act & ready & (ex_hit | ex_br);
  assign wr_cnt    = ex_hit ? cnt_update(ex_rd_cnt, ex_br) : BTB_CNT_ALLOC;
  assign wr_target = ex_br ? ex_br_target : ex_rd_target;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    clr        = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr        = 1'b1;
        init_idx_d = init_idx_q + IDX_W'(1);
        if (&init_idx_q) state_d = ST_RUN;
      end
      ST_RUN: begin
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign br_count_d      = br_count_q + 32'(ex_act);
  assign mispred_count_d = mispred_count_q + 32'(mispredict);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_INIT;
      init_idx_q      <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      state_q         <= state_d;
      init_idx_q      <= init_idx_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: vector table, directed corner sequences and
// random traffic checked against an array-based predictor model.
module tb_branch_predict_ctrl;
  import branch_predict_ctrl_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'h100;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_br = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_br_target = '0, ex_pred_target = '0;
  logic [2:0]  ex_br_type = '0;
  logic        redirect, flush_ifid, flush_idex, ready;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_br_type     (ex_br_type),
    .ex_br          (ex_br),
    .ex_br_target   (ex_br_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .ready          (ready),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  // ---------------- reference model ----------------
  bit          m_valid  [DEPTH];
  logic [31:0] m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_cnt    [DEPTH];
  int          m_init;
  logic [31:0] m_br, m_mis;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit m_ready();
    return m_init >= DEPTH;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i;
    i = ix(pc);
    return m_ready() && m_valid[i] && (m_tag[i] == (pc >> 8)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[ix(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_act();
    return ex_valid && !ex_stall && (ex_br_type != 3'd0);
  endfunction

  function automatic bit m_mis_now();
    return m_act() && ((ex_br != ex_pred_taken) ||
                       (ex_br && ex_pred_taken && ex_br_target != ex_pred_target));
  endfunction

  task automatic model_reset();
    m_init = 0;
    m_br   = 0;
    m_mis  = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
  endtask

  task automatic model_edge();
    bit rdy, act, mis;
    int i;
    rdy = m_ready();
    act = m_act();
    mis = m_mis_now();
    i   = ix(ex_pc);
    if (act) m_br++;
    if (mis) m_mis++;
    if (act && rdy) begin
      if (m_valid[i] && m_tag[i] == (ex_pc >> 8)) begin
        if (ex_br) begin
          m_cnt[i]    = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_target[i] = ex_br_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (ex_br) begin
        m_valid[i]  = 1;
        m_tag[i]    = ex_pc >> 8;
        m_target[i] = ex_br_target;
        m_cnt[i]    = 2;
      end
    end
    if (!rdy) m_init++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_comb(input string name);
    logic exp_mis;
    exp_mis = m_mis_now();
    chk({name, ".pred_taken"}, 32'(pred_taken), 32'(m_pred(if_pc)));
    chk({name, ".pred_target"}, pred_target, m_pred_tgt(if_pc));
    chk({name, ".redirect"}, 32'(redirect), 32'(exp_mis));
    chk({name, ".flush_ifid"}, 32'(flush_ifid), 32'(exp_mis));
    chk({name, ".flush_idex"}, 32'(flush_idex), 32'(exp_mis));
    chk({name, ".redirect_pc"}, redirect_pc, ex_br ? ex_br_target : ex_pc + 32'd4);
  endtask

  task automatic tick(input string name);
    $display("[%0t] %s if_pc=%h ex_pc=%h v=%0b s=%0b t=%0d br=%0b redirect=%0b rpc=%h",
             $time, name, if_pc, ex_pc, ex_valid, ex_stall, ex_br_type, ex_br, redirect, redirect_pc);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk({name, ".ready"}, 32'(ready), 32'(m_ready()));
    chk({name, ".br_count"}, br_count, m_br);
    chk({name, ".mispred_count"}, mispred_count, m_mis);
  endtask

  task automatic set_ex(input logic v, input logic s, input logic [2:0] t, input logic br,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_stall       = s;
    ex_br_type     = t;
    ex_br          = br;
    ex_pc          = pc;
    ex_br_target   = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, NOBRANCH, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v, s;
    logic [2:0]  t;
    logic        br;
    logic [31:0] pc, tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rpc, tgt_sel;
    int sel;

    vecs[0] = '{1, 0, BEQ,      1, 32'h40,       32'h10, 0, 32'h0,  1, 32'h10};
    vecs[1] = '{1, 0, BNE,      0, 32'h40,       32'h10, 1, 32'h10, 1, 32'h44};
    vecs[2] = '{1, 0, BLT,      1, 32'h40,       32'h10, 1, 32'h10, 0, 32'h10};
    vecs[3] = '{1, 0, BLTU,     1, 32'h40,       32'h20, 1, 32'h10, 1, 32'h20};
    vecs[4] = '{1, 0, BGE,      0, 32'h1000,     32'h5,  0, 32'h77, 0, 32'h1004};
    vecs[5] = '{0, 0, BEQ,      1, 32'h40,       32'h10, 0, 32'h0,  0, 32'h10};
    vecs[6] = '{1, 1, BGEU,     1, 32'h40,       32'h30, 0, 32'h0,  0, 32'h30};
    vecs[7] = '{1, 0, NOBRANCH, 1, 32'h40,       32'h30, 0, 32'h0,  0, 32'h30};
    vecs[8] = '{1, 0, BGEU,     0, 32'hfffffffc, 32'h30, 0, 32'h99, 0, 32'h0};
    vecs[9] = '{1, 0, BNE,      0, 32'h8,        32'h30, 1, 32'h30, 1, 32'hc};

    // Reset state
    idle();
    model_reset();
    if_pc = 32'h100;
    #1;
    chk("reset.ready", 32'(ready), 32'h0);
    chk("reset.br_count", br_count, 32'h0);
    chk("reset.mispred_count", mispred_count, 32'h0);
    chk("reset.pred_taken", 32'(pred_taken), 32'h0);
    chk("reset.pred_target", pred_target, 32'h104);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Redirect vectors while the table is still initialising
    for (int k = 0; k < 10; k++) begin
      set_ex(vecs[k].v, vecs[k].s, vecs[k].t, vecs[k].br, vecs[k].pc, vecs[k].tgt,
             vecs[k].pt, vecs[k].ptgt);
      #1;
      chk($sformatf("vec%0d.redirect", k), 32'(redirect), 32'(vecs[k].exp_redir));
      chk($sformatf("vec%0d.redirect_pc", k), redirect_pc, vecs[k].exp_rpc);
      check_comb($sformatf("vec%0d", k));
      tick($sformatf("vec%0d", k));
    end
    chk("vec.br_count", br_count, 32'd7);
    chk("vec.mispred_count", mispred_count, 32'd4);

    // Abort init at init_idx=30 with an asynchronous reset
    idle();
    while (m_init < 30) begin
      #1 check_comb("init_idle");
      tick("init_idle");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midinit.ready", 32'(ready), 32'h0);
    chk("midinit.br_count", br_count, 32'h0);
    chk("midinit.mispred_count", mispred_count, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Full init: ready low for 64 cycles, high on the 65th sample
    if_pc = 32'h100;
    for (int k = 0; k <= DEPTH; k++) begin
      #1;
      chk($sformatf("init%0d.ready", k), 32'(ready), 32'(k == DEPTH));
      chk($sformatf("init%0d.pred_taken", k), 32'(pred_taken), 32'h0);
      chk($sformatf("init%0d.pred_target", k), pred_target, 32'h104);
      check_comb("init");
      if (k < DEPTH) tick("init");
    end

    // First taken BEQ mispredicts and allocates
    set_ex(1, 0, BEQ, 1, 32'h100, 32'h80, 0, 32'h0);
    #1;
    chk("alloc.redirect", 32'(redirect), 32'h1);
    chk("alloc.redirect_pc", redirect_pc, 32'h80);
    chk("alloc.flush_ifid", 32'(flush_ifid), 32'h1);
    chk("alloc.flush_idex", 32'(flush_idex), 32'h1);
    chk("alloc.same_cycle_pred", 32'(pred_taken), 32'h0);
    check_comb("alloc");
    tick("alloc");
    chk("alloc.mispred_count", mispred_count, 32'd1);
    idle();
    #1;
    chk("alloc.pred_taken", 32'(pred_taken), 32'h1);
    chk("alloc.pred_target", pred_target, 32'h80);
    check_comb("alloc_lookup");
    tick("alloc_lookup");

    // Not-taken twice: 2->1 (mispredict), 1->0, then saturate at 0
    set_ex(1, 0, BEQ, 0, 32'h100, 32'h80, 1, 32'h80);
    #1;
    chk("nt1.redirect", 32'(redirect), 32'h1);
    chk("nt1.redirect_pc", redirect_pc, 32'h104);
    check_comb("nt1");
    tick("nt1");
    idle();
    #1;
    chk("nt1.pred_taken", 32'(pred_taken), 32'h0);
    chk("nt1.pred_target", pred_target, 32'h104);
    tick("nt1_lookup");
    for (int k = 0; k < 2; k++) begin
      set_ex(1, 0, BEQ, 0, 32'h100, 32'h80, 0, 32'h104);
      #1;
      chk($sformatf("nt%0d.redirect", k + 2), 32'(redirect), 32'h0);
      check_comb("nt");
      tick("nt");
    end
    chk("nt.mispred_count", mispred_count, 32'd2);
    chk("nt.br_count", br_count, 32'd4);
    idle();
    #1 chk("nt_sat.pred_taken", 32'(pred_taken), 32'h0);
    tick("nt_sat_lookup");

    // Train back up (0->1->2), then resolve taken to a new target
    for (int k = 0; k < 2; k++) begin
      set_ex(1, 0, BEQ, 1, 32'h100, 32'h80, 0, 32'h0);
      #1;
      chk("up.redirect", 32'(redirect), 32'h1);
      chk("up.redirect_pc", redirect_pc, 32'h80);
      tick("up");
      idle();
      #1 chk("up.pred_taken", 32'(pred_taken), 32'(k == 1));
      tick("up_lookup");
    end
    set_ex(1, 0, BEQ, 1, 32'h100, 32'h90, 1, 32'h80);
    #1;
    chk("retarget.redirect", 32'(redirect), 32'h1);
    chk("retarget.redirect_pc", redirect_pc, 32'h90);
    chk("retarget.same_cycle_target", pred_target, 32'h80);
    check_comb("retarget");
    tick("retarget");
    idle();
    #1;
    chk("retarget.pred_taken", 32'(pred_taken), 32'h1);
    chk("retarget.pred_target", pred_target, 32'h90);
    tick("retarget_lookup");
    chk("retarget.mispred_count", mispred_count, 32'd5);
    chk("retarget.br_count", br_count, 32'd7);

    // Stalled mispredicting branch has no effect until EX advances
    if_pc = 32'h200;
    set_ex(1, 1, BNE, 1, 32'h200, 32'h300, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d.redirect", k), 32'(redirect), 32'h0);
      chk($sformatf("stall%0d.flush_ifid", k), 32'(flush_ifid), 32'h0);
      tick("stall");
      chk($sformatf("stall%0d.br_count", k), br_count, 32'd7);
      chk($sformatf("stall%0d.mispred_count", k), mispred_count, 32'd5);
      chk($sformatf("stall%0d.pred_taken", k), 32'(pred_taken), 32'h0);
    end
    ex_stall = 1'b0;
    #1;
    chk("release.redirect", 32'(redirect), 32'h1);
    chk("release.redirect_pc", redirect_pc, 32'h300);
    tick("release");
    chk("release.br_count", br_count, 32'd8);
    chk("release.mispred_count", mispred_count, 32'd6);
    idle();
    #1;
    chk("release.pred_taken", 32'(pred_taken), 32'h1);
    chk("release.pred_target", pred_target, 32'h300);
    tick("release_lookup");

    // Random traffic over a few aliasing PCs
    for (int n = 0; n < 400; n++) begin
      rpc     = {22'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
      if_pc   = {22'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
      sel     = $urandom_range(0, 2);
      tgt_sel = 32'h400 + 32'(sel) * 32'h100;
      set_ex(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
             3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), rpc, tgt_sel, 1'b0, 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken  = m_pred(rpc);
        ex_pred_target = m_pred_tgt(rpc);
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = 32'h400 + 32'($urandom_range(0, 2)) * 32'h100;
      end
      #1 check_comb("rand");
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
